// File: rtl/fetch_queue.sv
// Instruction fetch buffer between fetch and decode: a DEPTH-entry {PC, instruction}
// FIFO with valid/ready on both sides and a single-cycle flush for redirects.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_ins,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_ins,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [WIDTH-1:0] mem_pc  [DEPTH];
  logic [WIDTH-1:0] mem_ins [DEPTH];

  logic push;
  logic pop;

  assign in_ready  = (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is read straight from storage; forced to zero when nothing is queued.
  assign out_pc  = out_valid ? mem_pc[rd_ptr_q]  : '0;
  assign out_ins = out_valid ? mem_ins[rd_ptr_q] : '0;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]  <= in_pc;
      mem_ins[wr_ptr_q] <= in_ins;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Redirect beats any same-cycle push or pop.
      state_d  = EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (count_d == '0)
        state_d = EMPTY;
      else if (count_d == CW'(DEPTH))
        state_d = FULL;
      else
        state_d = PARTIAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue; a queue-based reference model is
// updated on each edge and a negedge monitor compares every DUT output against it.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_pc = '0;
  logic [WIDTH-1:0] in_ins = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_ins;
  logic             flush = 1'b0;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  // Scoreboard: pairs still expected from the head, oldest first, as {pc, ins}.
  logic [2*WIDTH-1:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO rules stated directly on a queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
      automatic bit do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_pc, in_ins});
    end
  end

  // Monitor: compare the presented head and status against the model every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      automatic int n = exp_q.size();
      chk("count", 64'(count), 64'(n));
      chk("out_valid", 64'(out_valid), 64'(n > 0));
      chk("in_ready", 64'(in_ready), 64'((n < DEPTH) && !flush));
      if (n > 0) begin
        chk("head_pc", 64'(out_pc), 64'(exp_q[0][2*WIDTH-1:WIDTH]));
        chk("head_ins", 64'(out_ins), 64'(exp_q[0][WIDTH-1:0]));
        if (out_ready && !flush)
          $display("pop pc=%0h ins=%0h count=%0d", out_pc, out_ins, count);
      end else begin
        chk("empty_pc", 64'(out_pc), 64'd0);
        chk("empty_ins", 64'(out_ins), 64'd0);
      end
    end
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins,
                     input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_ins    = ins;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with in_valid asserted.
    rst = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h40;
    in_ins = 32'hDEAD;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ins", 64'(out_ins), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Fill to FULL; the fifth pair must be ignored.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_pc", 64'(out_pc), 64'h0);
    chk("full_head_ins", 64'(out_ins), 64'hA0);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_pc), 64'(4 * i));
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Two deep, then push and pop together so the pointers wrap.
    cyc(1'b1, 32'h100, 32'hB0, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 32'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 32'h108 + 32'(4 * i), 32'hB2 + 32'(i), 1'b1, 1'b0);
    chk("conc_count", 64'(count), 64'd2);
    chk("conc_head_pc", 64'(out_pc), 64'h118);

    // Bring to three entries then flush with push and pop asserted.
    cyc(1'b1, 32'h200, 32'hC0, 1'b0, 1'b0);
    cyc(1'b1, 32'h999, 32'hFF, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 32'h300, 32'hD0, 1'b0, 1'b0);
    chk("post_flush_head", 64'(out_pc), 64'h300);

    // Asynchronous reset pulsed between edges at count two.
    cyc(1'b1, 32'h304, 32'hD1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 32'h400, 32'hE0, 1'b0, 1'b0);
    chk("arst_push_head", 64'(out_pc), 64'h400);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    cyc(1'b0, '0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
